// File: rtl/adia_pkg.sv
// Shared types for the adiabatic power-clock scheduler: phase ramp states,
// scheduler FSM states and the level-code width helper.
package adia_pkg;

  typedef enum logic [1:0] {
    PH_EVAL  = 2'd0,
    PH_HOLD  = 2'd1,
    PH_RECOV = 2'd2,
    PH_WAIT  = 2'd3
  } ph_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ABORT = 2'd2
  } sched_state_t;

  function automatic int lvl_w(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/adia_phase_gen.sv
// One power-clock phase: ramp state/level from the shared quarter/step counters,
// plus the down-counter that ramps the phase to zero during an abort.
module adia_phase_gen
  import adia_pkg::*;
#(
  parameter int RAMP_STEPS = 8,
  parameter int CNT_W      = 8,
  parameter int QC_W       = CNT_W + 3,
  parameter int STEP_W     = 3,
  parameter int LVL_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         phase,
  input  logic [QC_W-1:0]    qc,
  input  logic [STEP_W-1:0]  step,
  input  logic [CNT_W-1:0]   ops,
  input  sched_state_t       fsm,
  output ph_state_t          state,
  output logic [LVL_W-1:0]   level
);

  logic [QC_W-1:0]  d;
  logic             act;
  ph_state_t        run_st;
  logic [LVL_W-1:0] run_lvl;
  logic [LVL_W-1:0] cnt;

  assign d   = qc - QC_W'(phase);
  assign act = (qc >= QC_W'(phase)) && (d < {1'b0, ops, 2'b00});

  always_comb begin
    run_st  = act ? ph_state_t'(d[1:0]) : PH_WAIT;
    run_lvl = '0;
    case (run_st)
      PH_EVAL:  run_lvl = LVL_W'(step) + LVL_W'(1);
      PH_HOLD:  run_lvl = LVL_W'(RAMP_STEPS);
      PH_RECOV: run_lvl = LVL_W'(RAMP_STEPS - 1) - LVL_W'(step);
      default:  run_lvl = '0;
    endcase
  end

  // Tracks one below the live level while running, so the first abort cycle
  // already steps down by one without a separate load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (fsm == RUN)
      cnt <= (run_lvl != '0) ? run_lvl - LVL_W'(1) : '0;
    else if (fsm == ABORT && cnt != '0)
      cnt <= cnt - LVL_W'(1);
  end

  always_comb begin
    state = PH_WAIT;
    level = '0;
    case (fsm)
      RUN: begin
        state = run_st;
        level = run_lvl;
      end
      ABORT: begin
        state = (cnt != '0) ? PH_RECOV : PH_WAIT;
        level = cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adia_clk_sched.sv
// Multi-phase trapezoidal power-clock scheduler for the adiabatic ALU.
// Optional ADIA_STALL_EN adds stall_i, which freezes the run in place.
module adia_clk_sched
  import adia_pkg::*;
#(
  parameter  int NUM_PHASES = 4,
  parameter  int RAMP_STEPS = 8,
  parameter  int CNT_W      = 8,
  localparam int LVL_W      = lvl_w(RAMP_STEPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            ops_i,
  input  logic                        abort_i,
`ifdef ADIA_STALL_EN
  input  logic                        stall_i,
`endif
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        aborted_o,
  output logic                        valid_o,
  output logic [2*NUM_PHASES-1:0]     ph_state_o,
  output logic [LVL_W*NUM_PHASES-1:0] ph_level_o
);

  localparam int QC_W   = CNT_W + 3;
  localparam int STEP_W = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;

  sched_state_t st, st_nx;
  logic [QC_W-1:0]   qc, q_last;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  ops;
  logic stall, step_wrap, last_cyc, all_zero, done_nx, aborted_nx;
  logic [NUM_PHASES-1:0][1:0]       pst;
  logic [NUM_PHASES-1:0][LVL_W-1:0] lvl;

`ifdef ADIA_STALL_EN
  assign stall = stall_i && (st == RUN);
`else
  assign stall = 1'b0;
`endif

  assign q_last    = {1'b0, ops, 2'b00} + QC_W'(NUM_PHASES - 2);
  assign step_wrap = (step == STEP_W'(RAMP_STEPS - 1));
  assign last_cyc  = step_wrap && (qc == q_last);
  assign all_zero  = (lvl == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      done_o    <= 1'b0;
      aborted_o <= 1'b0;
    end else begin
      st        <= st_nx;
      done_o    <= done_nx;
      aborted_o <= aborted_nx;
    end
  end

  // Stall outranks both completion and abort; completion outranks abort.
  always_comb begin
    st_nx      = st;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
    case (st)
      IDLE:
        if (start_i) begin
          if (ops_i != '0) st_nx = RUN;
          else             done_nx = 1'b1;
        end
      RUN:
        if (!stall) begin
          if (last_cyc) begin
            st_nx   = IDLE;
            done_nx = 1'b1;
          end else if (abort_i) begin
            st_nx = ABORT;
          end
        end
      ABORT:
        if (all_zero) begin
          st_nx      = IDLE;
          done_nx    = 1'b1;
          aborted_nx = 1'b1;
        end
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (st != IDLE);
    valid_o = (st == RUN) && !stall && step_wrap && (pst[NUM_PHASES-1] == PH_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qc   <= '0;
      step <= '0;
      ops  <= '0;
    end else if (st == IDLE) begin
      qc   <= '0;
      step <= '0;
      if (start_i) ops <= ops_i;
    end else if (st == RUN && !stall) begin
      if (step_wrap) begin
        step <= '0;
        qc   <= qc + QC_W'(1);
      end else begin
        step <= step + STEP_W'(1);
      end
    end
  end

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_ph
    adia_phase_gen #(
      .RAMP_STEPS (RAMP_STEPS),
      .CNT_W      (CNT_W),
      .QC_W       (QC_W),
      .STEP_W     (STEP_W),
      .LVL_W      (LVL_W)
    ) u_ph (
      .clk   (clk),
      .rst   (rst),
      .phase (3'(p)),
      .qc    (qc),
      .step  (step),
      .ops   (ops),
      .fsm   (st),
      .state (pst[p]),
      .level (lvl[p])
    );
  end

  assign ph_state_o = pst;
  assign ph_level_o = lvl;

endmodule
